winograd_scale_divider: RTL
===========================

# winograd_scale_divider

Parametrised post-transform normaliser for the Winograd datapath: divides every signed element of a ROWS×COLS matrix by a compile-time constant, with selectable rounding, processing LANES elements per cycle. It sits after the inverse-transform accumulation stage and replaces the fixed 8×10, divide-by-576, one-element-per-cycle, truncate-only normaliser. The input is captured on `start`, so upstream may change it while the divider runs.

## Interface
- ROWS, default 8: matrix rows, ≥1.
- COLS, default 10: matrix columns, ≥1.
- DATA_W, default 32: element width, two's-complement signed.
- DIVISOR, default 576: positive constant, ≥2.
- LANES, default 1: elements processed per cycle, 1..ROWS*COLS.
- clk  in  1: single clock, rising edge.
- rst  in  1: synchronous, active-high reset.
- start  in  1: begin operation; honoured only in IDLE.
- abort  in  1: cancel a running operation.
- round_mode  in  2: 0 truncate toward zero, 1 round half away from zero, 2 floor, 3 treated as 0; latched on accepted start.
- input_array  in  [ROWS][COLS]×DATA_W: source matrix.
- output_array  out  [ROWS][COLS]×DATA_W: result store, held between operations.
- busy  out  1: high from the cycle after accepted start until the done cycle, exclusive.
- done  out  1: one-cycle pulse, results complete.
- start_err  out  1: sticky; set when start is high while busy; cleared by rst or by the next accepted start.

## Operation
- Reset: output_array all 0, busy 0, done 0, start_err 0, FSM IDLE, counters 0. Reset mid-operation discards all work; no done.
- FSM: IDLE → RUN on start && !abort (snapshot input_array, latch round_mode, group counter g=0). RUN issues group g each cycle; after the last group → DRAIN. DRAIN writes the final group, pulses done → IDLE.
- N = ceil(ROWS*COLS/LANES) groups. Group g covers flat row-major indices g*LANES+l, l=0..LANES-1; flat index f maps to row f/COLS, col f%COLS. Lanes with f ≥ ROWS*COLS are masked and write nothing.
- Per lane: q = x/DIVISOR truncated toward zero, r = x − q·DIVISOR. Mode 1: if 2|r| ≥ DIVISOR, q += sign(x). Mode 2: if r≠0 and x<0, q −= 1. Compute r and 2|r| at DATA_W+1 bits; the result always fits DATA_W because DIVISOR ≥ 2.
- abort in RUN or DRAIN: to IDLE next cycle, no done, busy drops; elements already written keep their new values; in-flight group discarded. abort in IDLE: no effect, and start is not accepted that cycle.
- start in RUN/DRAIN: ignored, sets start_err. start during the done cycle is accepted (FSM is then IDLE).

## Timing
- Cycle 0: start sampled in IDLE. Cycles 1..N: group g=k−1 computed into the lane pipeline register. Edge ending cycle k+1 writes group k−1 to output_array.
- Last write at the edge ending cycle N+1; done high in cycle N+2, when output_array is complete. Total latency N+2 cycles start-to-done; back-to-back start earliest in cycle N+2.
- Default (80 elements, LANES=1): done in cycle 82. LANES=8: N=10, done in cycle 12. LANES=3: N=27, last group has 2 valid lanes.
- output_array elements change only at their write edge; unwritten elements hold previous values.

## Structure
- Shared package winograd_pkg: round_mode_e typedef (RND_TRUNC, RND_HALF_AWAY, RND_FLOOR), FSM state typedef, default constants WINO_ROWS/COLS/DIVISOR.
- Sub-module winograd_const_div_lane: one lane, parameters DATA_W and DIVISOR, one registered stage (input x, mode, valid → q, valid). Top instantiates LANES copies plus the FSM, snapshot, group counter and write mask.

## Test plan
- Defaults, mode 0, element [0][0]=−577, [7][9]=1151, others 575: [0][0]=−1, [7][9]=1, others 0; done exactly in cycle 82, busy high in cycles 1..81.
- Mode 1 with x=288, −288, 287; mode 2 with x=−1, −577, 576: 1, −1, 0; −1, −2, 1.
- LANES=3, ROWS=8, COLS=10, ramp input f·576: output f; done in cycle 29; masked lane writes nothing.
- Change input_array every cycle during RUN: outputs match the snapshot at start; start pulse at cycle 5 sets start_err, no restart.
- abort at cycle 10 (LANES=1): elements 0..8 updated, rest unchanged, no done, IDLE next cycle; rst at cycle 20 of a new run: all outputs 0, no done.
- DIVISOR=2, DATA_W=8, x=−128 mode 2 → −64, x=127 mode 1 → 64: no overflow.

Source files
------------

// File: rtl/winograd_pkg.sv
// Shared types and default geometry for the Winograd post-transform normaliser.
package winograd_pkg;

  typedef enum logic [1:0] {
    RND_TRUNC     = 2'd0,
    RND_HALF_AWAY = 2'd1,
    RND_FLOOR     = 2'd2
  } round_mode_e;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t ST_IDLE  = 2'd0;
  localparam fsm_state_t ST_RUN   = 2'd1;
  localparam fsm_state_t ST_DRAIN = 2'd2;

  localparam int WINO_ROWS    = 8;
  localparam int WINO_COLS    = 10;
  localparam int WINO_DIVISOR = 576;

endpackage

// File: rtl/winograd_const_div_lane.sv
// One divide-by-constant lane with selectable rounding and a single register stage.
module winograd_const_div_lane
  import winograd_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DIVISOR = 576
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] x,
  input  round_mode_e              mode,
  input  logic                     vld,
  output logic signed [DATA_W-1:0] q,
  output logic                     q_vld
);

  localparam logic signed [DATA_W:0] DIV_S = (DATA_W+1)'(DIVISOR);
  localparam logic        [DATA_W:0] DIV_U = (DATA_W+1)'(DIVISOR);
  localparam logic signed [DATA_W:0] ONE_S = (DATA_W+1)'(1);

  logic signed [DATA_W-1:0] q_p1;
  logic                     vld_p1;

  // One guard bit keeps the remainder and its doubled magnitude exact.
  function automatic logic signed [DATA_W-1:0] div_round(
    input logic signed [DATA_W-1:0] xv,
    input round_mode_e              m
  );
    logic signed [DATA_W:0] xe;
    logic signed [DATA_W:0] qe;
    logic signed [DATA_W:0] re;
    logic signed [DATA_W:0] are;
    logic        [DATA_W:0] r2;
    xe  = {xv[DATA_W-1], xv};
    qe  = xe / DIV_S;
    re  = xe - qe * DIV_S;
    are = re[DATA_W] ? -re : re;
    r2  = {are[DATA_W-1:0], 1'b0};
    case (m)
      RND_HALF_AWAY: if (r2 >= DIV_U) qe = xv[DATA_W-1] ? qe - ONE_S : qe + ONE_S;
      RND_FLOOR:     if ((|re) && xv[DATA_W-1]) qe = qe - ONE_S;
      default:       qe = qe;
    endcase
    return qe[DATA_W-1:0];
  endfunction

  // Stage p0 -> p1: rounded quotient registered alongside its valid.
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= vld;
  end

  always_ff @(posedge clk) begin
    q_p1 <= div_round(x, mode);
  end

  assign q     = q_p1;
  assign q_vld = vld_p1;

endmodule

// File: rtl/winograd_scale_divider.sv
// Post-transform normaliser: snapshots a ROWS x COLS matrix and divides it by a
// constant, LANES elements per cycle, writing results into a held output store.
module winograd_scale_divider
  import winograd_pkg::*;
#(
  parameter int ROWS    = WINO_ROWS,
  parameter int COLS    = WINO_COLS,
  parameter int DATA_W  = 32,
  parameter int DIVISOR = WINO_DIVISOR,
  parameter int LANES   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [1:0]               round_mode,
  input  logic signed [DATA_W-1:0] input_array  [ROWS][COLS],
  output logic signed [DATA_W-1:0] output_array [ROWS][COLS],
  output logic                     busy,
  output logic                     done,
  output logic                     start_err
);

  localparam int ELEMS = ROWS * COLS;
  localparam int NGRP  = (ELEMS + LANES - 1) / LANES;
  localparam int GW    = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int IW    = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam int FW    = $clog2(NGRP * LANES + 1);

  fsm_state_t  state;
  logic [GW-1:0] grp;
  logic [GW-1:0] grp_p1;
  round_mode_e mode_r;
  logic        accept;
  logic        issue;

  logic signed [DATA_W-1:0] in_flat  [ELEMS];
  logic signed [DATA_W-1:0] snap     [ELEMS];
  logic signed [DATA_W-1:0] out_flat [ELEMS];

  logic signed [DATA_W-1:0] lane_x [LANES];
  logic signed [DATA_W-1:0] lane_q [LANES];
  logic [LANES-1:0]         lane_vld;
  logic [LANES-1:0]         lane_qv;
  logic [IW-1:0]            wr_idx [LANES];

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      assign in_flat[r*COLS+c]      = input_array[r][c];
      assign output_array[r][c]     = out_flat[r*COLS+c];
    end
  end

  assign accept = (state == ST_IDLE) && start && !abort;
  assign issue  = (state == ST_RUN) && !abort;
  assign busy   = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (accept) snap <= in_flat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      grp       <= '0;
      grp_p1    <= '0;
      mode_r    <= RND_TRUNC;
      done      <= 1'b0;
      start_err <= 1'b0;
    end else begin
      done   <= 1'b0;
      grp_p1 <= grp;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_RUN;
            grp       <= '0;
            start_err <= 1'b0;
            mode_r    <= (round_mode == 2'd3) ? RND_TRUNC : round_mode_e'(round_mode);
          end
        end
        ST_RUN: begin
          if (start) start_err <= 1'b1;
          if (abort)                          state <= ST_IDLE;
          else if (grp == GW'(NGRP - 1))      state <= ST_DRAIN;
          else                                grp   <= grp + GW'(1);
        end
        ST_DRAIN: begin
          if (start) start_err <= 1'b1;
          state <= ST_IDLE;
          if (!abort) done <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Group g lanes read snapshot f = g*LANES+l; lanes past the matrix end stay idle.
  always_comb begin
    logic [FW-1:0] fi;
    logic [FW-1:0] wf;
    for (int l = 0; l < LANES; l++) begin
      fi          = FW'(grp) * FW'(LANES) + FW'(l);
      wf          = FW'(grp_p1) * FW'(LANES) + FW'(l);
      lane_vld[l] = issue && (fi < FW'(ELEMS));
      lane_x[l]   = lane_vld[l] ? snap[fi[IW-1:0]] : '0;
      wr_idx[l]   = wf[IW-1:0];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    winograd_const_div_lane #(
      .DATA_W  (DATA_W),
      .DIVISOR (DIVISOR)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .x     (lane_x[l]),
      .mode  (mode_r),
      .vld   (lane_vld[l]),
      .q     (lane_q[l]),
      .q_vld (lane_qv[l])
    );
  end

  // Stage p1 -> store: registered lane results land in the output matrix.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_flat <= '{default: '0};
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (lane_qv[l]) out_flat[wr_idx[l]] <= lane_q[l];
      end
    end
  end

endmodule
